mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single read port and single write port of the core's bus bridge between the
//  instruction side (IF_* from the icache/uncache select) and the data side (MEM_*). Reads
//  are arbitrated, with data-side priority and a starvation guard for the instruction side.
//  Data-side writes go through a one-entry write buffer. A data read that hits the line held
//  in that buffer is held off until the write completes.
// PARAMETERS
//  LINE_WORDS  4  32-bit words per cache line; the number of beats of a line read or write
//  MAX_MEM_RUN 4  consecutive MEM read grants allowed while IF is waiting; IF is granted next
// PORTS
//  clk            in   1    core clock
//  resetn         in   1    asynchronous, active-low reset
//  IF_rd_req      in   1    instruction read request; held until IF_rd_rdy
//  IF_rd_type     in   3    000 byte, 001 half, 010 word, 100 line
//  IF_rd_addr     in   32   physical address
//  IF_rd_rdy      out  1    request accepted this cycle
//  IF_ret_valid   out  1    return beat for IF
//  IF_ret_last    out  1    last beat of the IF return
//  MEM_rd_req     in   1    data read request; same rules as IF
//  MEM_rd_type    in   3    encoding as IF_rd_type
//  MEM_rd_addr    in   32   physical address
//  MEM_rd_rdy     out  1    request accepted this cycle
//  MEM_ret_valid  out  1    return beat for MEM
//  MEM_ret_last   out  1    last beat of the MEM return
//  ret_data       out  32   return data, shared by both sides; qualified by *_ret_valid
//  MEM_wr_req     in   1    data write request
//  MEM_wr_type    in   3    encoding as rd_type
//  MEM_wr_addr    in   32   physical address
//  MEM_wr_wstrb   in   4    byte strobes; used when the type is not a line
//  MEM_wr_data    in   32*LINE_WORDS  write data; word 0 in bits [31:0]
//  MEM_wr_rdy     out  1    write buffer is empty, so the write is accepted this cycle
//  bus_rd_req     out  1    read request to the bridge
//  bus_rd_type    out  3    read type to the bridge
//  bus_rd_addr    out  32   read address to the bridge
//  bus_rd_rdy     in   1    bridge accepted the read request
//  bus_ret_valid  in   1    return beat from the bridge
//  bus_ret_last   in   1    last return beat from the bridge
//  bus_ret_data   in   32   return data from the bridge
//  bus_wr_req     out  1    write request to the bridge
//  bus_wr_type    out  3    write type to the bridge
//  bus_wr_addr    out  32   write address to the bridge
//  bus_wr_wstrb   out  4    write strobes to the bridge
//  bus_wr_data    out  32*LINE_WORDS  write data to the bridge
//  bus_wr_rdy     in   1    bridge accepted the write request
//  bus_wr_done    in   1    write response received; pulses for 1 cycle
// BEHAVIOUR
//  Reset: all outputs are 0. Read FSM is in R_IDLE, write buffer is empty, mem_run = 0.
//  Read FSM states: R_IDLE -> R_REQ -> R_RESP -> R_IDLE. The grant is held in a register, owner.
//   R_IDLE: select a winner and latch owner, type and addr. Go to R_REQ.
//    - MEM wins when MEM_rd_req is set and the read is not hazard-blocked, unless
//      mem_run == MAX_MEM_RUN and IF_rd_req is set; in that case IF wins.
//    - Otherwise IF wins when IF_rd_req is set.
//   Winner's *_rd_rdy: 1-cycle pulse in the R_IDLE cycle that picks it. Never asserted at the
//    same time for both sides.
//   R_REQ: bus_rd_req = 1 with the latched type and addr. On bus_rd_rdy, go to R_RESP.
//   R_RESP: owner's *_ret_valid and *_ret_last follow bus_ret_valid and bus_ret_last
//    combinationally. ret_data = bus_ret_data. On valid && last, go to R_IDLE.
//   Minimum latency from request to bus_rd_req is 1 cycle. A new grant can be made in the
//    cycle after the last beat.
//  mem_run counter:
//   - MEM grant: +1 when IF_rd_req is set, saturating at MAX_MEM_RUN.
//   - IF grant: cleared to 0.
//   - MEM grant with IF idle: cleared to 0.
//  Write buffer (one entry, flag wb_valid):
//   - MEM_wr_rdy = !wb_valid. A write is accepted when MEM_wr_req && MEM_wr_rdy; type, addr,
//     wstrb and data are latched and wb_valid is set.
//   - The entry is presented on bus_wr_* with bus_wr_req = 1 until bus_wr_rdy. bus_wr_req
//     then drops, but wb_valid stays set until bus_wr_done.
//   - bus_wr_done clears wb_valid. If an accept happens in the same cycle, wb_valid stays set
//     and the new entry is loaded. bus_wr_req for the new entry starts the cycle after.
//   - Writes and reads run independently. A bus_wr_done with no write outstanding is ignored.
//  Hazard: a MEM read is blocked when wb_valid && MEM_rd_addr[31:4] == wb_addr[31:4] (line
//   match, 16-byte line). A blocked MEM read does not stop IF being granted.
//  Reset in mid-operation clears every state at once. The bridge is reset by the same resetn.
// STRUCTURE
//  Shared package / `include: rd/wr type encodings, R_IDLE/R_REQ/R_RESP state codes, the
//   OWNER_IF/OWNER_MEM constants.
//  One sub-module: mem_wr_buffer, holding the write entry, wb_valid, the bus_wr_* handshake
//   and the line-match output. The read FSM, priority logic and mem_run stay at top level.
// TESTING
//  1 Both sides idle; IF line read at addr 0x1fc00000; bridge returns 4 beats -> IF_rd_rdy
//    pulse, bus_rd_type = 100, IF_ret_last on beat 4, MEM_ret_valid stays 0.
//  2 IF and MEM request together, MEM addr 0x00001000 -> MEM granted first; IF granted in the
//    cycle after MEM's last beat.
//  3 MEM requests back to back with IF held pending, MAX_MEM_RUN = 4 -> exactly 4 MEM grants,
//    then an IF grant; mem_run reads 0 after it.
//  4 MEM line write to 0x00002000 held in the buffer (bus_wr_done withheld); MEM read of
//    0x00002008 -> no MEM_rd_rdy until the cycle after bus_wr_done; IF reads still granted.
//  5 bus_wr_done and a new MEM_wr_req in the same cycle -> wb_valid stays 1; the new entry's
//    bus_wr_req rises the next cycle with the new address.
//  6 resetn pulsed low in R_RESP, during beat 2 -> all outputs 0 right away; after release a
//    fresh IF read completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus transfer type encodings,
// read-FSM state codes and read-grant owner codes.
package mem_bus_arbiter_pkg;

  // Transfer sizes on the rd/wr type fields
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // Read FSM states
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  // Side that holds the current read grant
  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_wr_buffer.sv
// One-entry data-side write buffer in front of the bus bridge write port.
// Ports:
//   i_clk, i_resetn          clock, asynchronous active-low reset
//   i_wr_*                   write request from the data side
//   o_wr_rdy                 buffer can take a write this cycle
//   i_rd_line                line address (addr[31:4]) of the pending data read
//   o_hit                    pending data read falls in the buffered line
//   o_bus_wr_*               entry presented to the bridge
//   i_bus_wr_rdy             bridge accepted the write request
//   i_bus_wr_done            bridge write response (1-cycle pulse)
module mem_wr_buffer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic                      i_wr_req,
  input  logic [2:0]                i_wr_type,
  input  logic [31:0]               i_wr_addr,
  input  logic [3:0]                i_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  i_wr_data,
  output logic                      o_wr_rdy,
  input  logic [27:0]               i_rd_line,
  output logic                      o_hit,
  output logic                      o_bus_wr_req,
  output logic [2:0]                o_bus_wr_type,
  output logic [31:0]               o_bus_wr_addr,
  output logic [3:0]                o_bus_wr_wstrb,
  output logic [32*LINE_WORDS-1:0]  o_bus_wr_data,
  input  logic                      i_bus_wr_rdy,
  input  logic                      i_bus_wr_done
);

  logic                     r_wb_valid;
  logic                     r_wr_pend;
  logic [2:0]               r_type;
  logic [31:0]              r_addr;
  logic [3:0]               r_wstrb;
  logic [32*LINE_WORDS-1:0] r_data;

  logic w_done;
  logic w_free;
  logic w_accept;

  // A response only counts once the bridge has taken the request; stray pulses are dropped.
  assign w_done   = i_bus_wr_done && r_wb_valid && !r_wr_pend;
  // The completing response frees the slot in the same cycle so a new write can load behind it.
  assign w_free   = !r_wb_valid || w_done;
  assign w_accept = i_wr_req && w_free;
  assign o_wr_rdy = i_resetn && w_free;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wb_valid <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_type     <= '0;
      r_addr     <= '0;
      r_wstrb    <= '0;
      r_data     <= '0;
    end else if (w_accept) begin
      r_wb_valid <= 1'b1;
      r_wr_pend  <= 1'b1;
      r_type     <= i_wr_type;
      r_addr     <= i_wr_addr;
      r_wstrb    <= i_wr_wstrb;
      r_data     <= i_wr_data;
    end else begin
      if (w_done)
        r_wb_valid <= 1'b0;
      if (r_wr_pend && i_bus_wr_rdy)
        r_wr_pend <= 1'b0;
    end
  end

  // 16-byte line match against the buffered write
  assign o_hit = r_wb_valid && (i_rd_line == r_addr[31:4]);

  assign o_bus_wr_req   = r_wr_pend;
  assign o_bus_wr_type  = r_type;
  assign o_bus_wr_addr  = r_addr;
  assign o_bus_wr_wstrb = r_wstrb;
  assign o_bus_wr_data  = r_data;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the bus bridge read and write ports between the instruction side (IF_*)
// and the data side (MEM_*). Reads are arbitrated with data-side priority and a
// starvation guard for IF; data writes go through a one-entry write buffer, and a
// data read that hits the buffered line waits until that write completes.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   IF_rd_* / IF_ret_*       instruction read request and return
//   MEM_rd_* / MEM_ret_*     data read request and return
//   ret_data                 shared return data, qualified by *_ret_valid
//   MEM_wr_*                 data write request
//   bus_rd_* / bus_ret_*     bridge read port
//   bus_wr_*                 bridge write port
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_WORDS  = 4,
  parameter int MAX_MEM_RUN = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      IF_rd_req,
  input  logic [2:0]                IF_rd_type,
  input  logic [31:0]               IF_rd_addr,
  output logic                      IF_rd_rdy,
  output logic                      IF_ret_valid,
  output logic                      IF_ret_last,
  input  logic                      MEM_rd_req,
  input  logic [2:0]                MEM_rd_type,
  input  logic [31:0]               MEM_rd_addr,
  output logic                      MEM_rd_rdy,
  output logic                      MEM_ret_valid,
  output logic                      MEM_ret_last,
  output logic [31:0]               ret_data,
  input  logic                      MEM_wr_req,
  input  logic [2:0]                MEM_wr_type,
  input  logic [31:0]               MEM_wr_addr,
  input  logic [3:0]                MEM_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  MEM_wr_data,
  output logic                      MEM_wr_rdy,
  output logic                      bus_rd_req,
  output logic [2:0]                bus_rd_type,
  output logic [31:0]               bus_rd_addr,
  input  logic                      bus_rd_rdy,
  input  logic                      bus_ret_valid,
  input  logic                      bus_ret_last,
  input  logic [31:0]               bus_ret_data,
  output logic                      bus_wr_req,
  output logic [2:0]                bus_wr_type,
  output logic [31:0]               bus_wr_addr,
  output logic [3:0]                bus_wr_wstrb,
  output logic [32*LINE_WORDS-1:0]  bus_wr_data,
  input  logic                      bus_wr_rdy,
  input  logic                      bus_wr_done
);

  localparam int RUN_W = $clog2(MAX_MEM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_MEM_RUN);

  rd_state_t        r_state;
  rd_state_t        w_next;
  owner_t           r_owner;
  logic [2:0]       r_rd_type;
  logic [31:0]      r_rd_addr;
  logic [RUN_W-1:0] r_mem_run;

  logic w_hazard;
  logic w_idle;
  logic w_force_if;
  logic w_gnt_mem;
  logic w_gnt_if;

  mem_wr_buffer #(.LINE_WORDS(LINE_WORDS)) u_wb (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_wr_req       (MEM_wr_req),
    .i_wr_type      (MEM_wr_type),
    .i_wr_addr      (MEM_wr_addr),
    .i_wr_wstrb     (MEM_wr_wstrb),
    .i_wr_data      (MEM_wr_data),
    .o_wr_rdy       (MEM_wr_rdy),
    .i_rd_line      (MEM_rd_addr[31:4]),
    .o_hit          (w_hazard),
    .o_bus_wr_req   (bus_wr_req),
    .o_bus_wr_type  (bus_wr_type),
    .o_bus_wr_addr  (bus_wr_addr),
    .o_bus_wr_wstrb (bus_wr_wstrb),
    .o_bus_wr_data  (bus_wr_data),
    .i_bus_wr_rdy   (bus_wr_rdy),
    .i_bus_wr_done  (bus_wr_done)
  );

  // Grant selection. resetn gates the idle flag so no rdy pulse leaks out while reset is held.
  assign w_idle     = (r_state == R_IDLE) && resetn;
  assign w_force_if = (r_mem_run == RUN_MAX) && IF_rd_req;
  assign w_gnt_mem  = w_idle && MEM_rd_req && !w_hazard && !w_force_if;
  assign w_gnt_if   = w_idle && IF_rd_req && !w_gnt_mem;

  // State register plus the request latched at grant time
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      r_owner   <= OWNER_IF;
      r_rd_type <= '0;
      r_rd_addr <= '0;
      r_mem_run <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_mem) begin
        r_owner   <= OWNER_MEM;
        r_rd_type <= MEM_rd_type;
        r_rd_addr <= MEM_rd_addr;
        // Run length only grows while IF is actually being held off
        if (!IF_rd_req)
          r_mem_run <= '0;
        else if (r_mem_run != RUN_MAX)
          r_mem_run <= r_mem_run + RUN_W'(1);
      end else if (w_gnt_if) begin
        r_owner   <= OWNER_IF;
        r_rd_type <= IF_rd_type;
        r_rd_addr <= IF_rd_addr;
        r_mem_run <= '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      R_IDLE:  if (w_gnt_mem || w_gnt_if)          w_next = R_REQ;
      R_REQ:   if (bus_rd_rdy)                     w_next = R_RESP;
      R_RESP:  if (bus_ret_valid && bus_ret_last)  w_next = R_IDLE;
      default:                                     w_next = R_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    IF_rd_rdy     = w_gnt_if;
    MEM_rd_rdy    = w_gnt_mem;
    IF_ret_valid  = 1'b0;
    IF_ret_last   = 1'b0;
    MEM_ret_valid = 1'b0;
    MEM_ret_last  = 1'b0;
    ret_data      = '0;
    bus_rd_req    = 1'b0;
    unique case (r_state)
      R_REQ: bus_rd_req = 1'b1;
      R_RESP: begin
        ret_data = bus_ret_data;
        if (r_owner == OWNER_MEM) begin
          MEM_ret_valid = bus_ret_valid;
          MEM_ret_last  = bus_ret_last;
        end else begin
          IF_ret_valid  = bus_ret_valid;
          IF_ret_last   = bus_ret_last;
        end
      end
      default: ;
    endcase
  end

  assign bus_rd_type = r_rd_type;
  assign bus_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LW   = 4;
  localparam int MAXR = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              IF_rd_req, IF_rd_rdy, IF_ret_valid, IF_ret_last;
  logic [2:0]        IF_rd_type;
  logic [31:0]       IF_rd_addr;
  logic              MEM_rd_req, MEM_rd_rdy, MEM_ret_valid, MEM_ret_last;
  logic [2:0]        MEM_rd_type;
  logic [31:0]       MEM_rd_addr;
  logic [31:0]       ret_data;
  logic              MEM_wr_req, MEM_wr_rdy;
  logic [2:0]        MEM_wr_type;
  logic [31:0]       MEM_wr_addr;
  logic [3:0]        MEM_wr_wstrb;
  logic [32*LW-1:0]  MEM_wr_data;
  logic              bus_rd_req, bus_rd_rdy, bus_ret_valid, bus_ret_last;
  logic [2:0]        bus_rd_type;
  logic [31:0]       bus_rd_addr, bus_ret_data;
  logic              bus_wr_req, bus_wr_rdy, bus_wr_done;
  logic [2:0]        bus_wr_type;
  logic [31:0]       bus_wr_addr;
  logic [3:0]        bus_wr_wstrb;
  logic [32*LW-1:0]  bus_wr_data;

  mem_bus_arbiter #(.LINE_WORDS(LW), .MAX_MEM_RUN(MAXR)) dut (
    .clk(clk), .resetn(resetn),
    .IF_rd_req(IF_rd_req), .IF_rd_type(IF_rd_type), .IF_rd_addr(IF_rd_addr),
    .IF_rd_rdy(IF_rd_rdy), .IF_ret_valid(IF_ret_valid), .IF_ret_last(IF_ret_last),
    .MEM_rd_req(MEM_rd_req), .MEM_rd_type(MEM_rd_type), .MEM_rd_addr(MEM_rd_addr),
    .MEM_rd_rdy(MEM_rd_rdy), .MEM_ret_valid(MEM_ret_valid), .MEM_ret_last(MEM_ret_last),
    .ret_data(ret_data),
    .MEM_wr_req(MEM_wr_req), .MEM_wr_type(MEM_wr_type), .MEM_wr_addr(MEM_wr_addr),
    .MEM_wr_wstrb(MEM_wr_wstrb), .MEM_wr_data(MEM_wr_data), .MEM_wr_rdy(MEM_wr_rdy),
    .bus_rd_req(bus_rd_req), .bus_rd_type(bus_rd_type), .bus_rd_addr(bus_rd_addr),
    .bus_rd_rdy(bus_rd_rdy), .bus_ret_valid(bus_ret_valid), .bus_ret_last(bus_ret_last),
    .bus_ret_data(bus_ret_data),
    .bus_wr_req(bus_wr_req), .bus_wr_type(bus_wr_type), .bus_wr_addr(bus_wr_addr),
    .bus_wr_wstrb(bus_wr_wstrb), .bus_wr_data(bus_wr_data), .bus_wr_rdy(bus_wr_rdy),
    .bus_wr_done(bus_wr_done)
  );

  always #5 clk = ~clk;

  logic [242:0] all_out;
  assign all_out = {IF_rd_rdy, IF_ret_valid, IF_ret_last, MEM_rd_rdy, MEM_ret_valid,
                    MEM_ret_last, ret_data, MEM_wr_rdy, bus_rd_req, bus_rd_type, bus_rd_addr,
                    bus_wr_req, bus_wr_type, bus_wr_addr, bus_wr_wstrb, bus_wr_data};

  int total = 0;
  int bad   = 0;
  int m_run = 0;   // reference model of the MEM run counter

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: 0 = no grant, 1 = IF, 2 = MEM
  function automatic int pick(input bit ifr, input bit memr, input bit blk);
    if (memr && !blk && !(m_run == MAXR && ifr)) return 2;
    if (ifr) return 1;
    return 0;
  endfunction

  task automatic model_grant(input int g, input bit ifr);
    if (g == 2) m_run = ifr ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
    else if (g == 1) m_run = 0;
  endtask

  function automatic logic [2:0] rtype();
    case ($urandom_range(0, 3))
      0:       return TYPE_BYTE;
      1:       return TYPE_HALF;
      2:       return TYPE_WORD;
      default: return TYPE_LINE;
    endcase
  endfunction

  // Bridge side of one read; entered in the first R_REQ cycle, leaves in the following idle cycle.
  task automatic serve_read(input bit own_mem, input logic [2:0] t, input logic [31:0] a);
    int nb, w, gap;
    logic [31:0] d;
    nb = (t == TYPE_LINE) ? LW : 1;
    w  = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      #1 chk("req_hold", bus_rd_req, 1'b1);
      step();
    end
    bus_rd_rdy = 1'b1;
    #1;
    chk("req_valid", bus_rd_req, 1'b1);
    chk("req_type", bus_rd_type, t);
    chk("req_addr", bus_rd_addr, a);
    chk("req_no_rdy", {IF_rd_rdy, MEM_rd_rdy}, 2'b00);
    step();
    bus_rd_rdy = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bus_ret_valid = 1'b0;
      bus_ret_last  = 1'b0;
      gap = $urandom_range(0, 1);
      for (int i = 0; i < gap; i++) begin
        #1 chk("ret_idle", {IF_ret_valid, MEM_ret_valid, bus_rd_req}, 3'b000);
        step();
      end
      d = $urandom;
      bus_ret_valid = 1'b1;
      bus_ret_last  = (b == nb - 1);
      bus_ret_data  = d;
      #1;
      chk("ret_valid", {IF_ret_valid, MEM_ret_valid}, own_mem ? 2'b01 : 2'b10);
      chk("ret_last", own_mem ? MEM_ret_last : IF_ret_last, (b == nb - 1));
      chk("ret_data", ret_data, d);
      chk("resp_no_rdy", {IF_rd_rdy, MEM_rd_rdy}, 2'b00);
      step();
    end
    bus_ret_valid = 1'b0;
    bus_ret_last  = 1'b0;
    bus_ret_data  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int g, nmem;
    bit done3, if_p, mem_p;
    logic [2:0]       if_t, mem_t;
    logic [31:0]      if_a, mem_a;
    logic [32*LW-1:0] wd;

    resetn = 1'b0;
    IF_rd_req = 0; IF_rd_type = 0; IF_rd_addr = 0;
    MEM_rd_req = 0; MEM_rd_type = 0; MEM_rd_addr = 0;
    MEM_wr_req = 0; MEM_wr_type = 0; MEM_wr_addr = 0; MEM_wr_wstrb = 0; MEM_wr_data = 0;
    bus_rd_rdy = 0; bus_ret_valid = 0; bus_ret_last = 0; bus_ret_data = 0;
    bus_wr_rdy = 0; bus_wr_done = 0;
    step(); step();
    #1 chk("reset_outputs", all_out, '0);
    resetn = 1'b1;
    step();
    #1 chk("post_reset_wr_rdy", MEM_wr_rdy, 1'b1);

    // 1: lone IF line read
    IF_rd_req = 1; IF_rd_type = TYPE_LINE; IF_rd_addr = 32'h1fc0_0000;
    #1;
    chk("t1_if_rdy", IF_rd_rdy, 1'b1);
    chk("t1_mem_rdy", MEM_rd_rdy, 1'b0);
    chk("t1_bus_req_early", bus_rd_req, 1'b0);
    model_grant(1, 1);
    step();
    IF_rd_req = 0;
    serve_read(0, TYPE_LINE, 32'h1fc0_0000);
    #1 chk("t1_back_idle", bus_rd_req, 1'b0);

    // 2: simultaneous requests, MEM first then IF right after
    IF_rd_req = 1; IF_rd_type = TYPE_WORD; IF_rd_addr = 32'h1fc0_0010;
    MEM_rd_req = 1; MEM_rd_type = TYPE_LINE; MEM_rd_addr = 32'h0000_1000;
    #1;
    chk("t2_mem_rdy", MEM_rd_rdy, 1'b1);
    chk("t2_if_wait", IF_rd_rdy, 1'b0);
    model_grant(2, 1);
    step();
    MEM_rd_req = 0;
    serve_read(1, TYPE_LINE, 32'h0000_1000);
    #1 chk("t2_if_rdy_after", IF_rd_rdy, 1'b1);
    model_grant(1, 1);
    step();
    IF_rd_req = 0;
    serve_read(0, TYPE_WORD, 32'h1fc0_0010);

    // 3: MEM back to back with IF pending -> MAXR MEM grants, then IF
    IF_rd_req = 1; IF_rd_type = TYPE_WORD; IF_rd_addr = 32'h1fc0_0100;
    MEM_rd_req = 1; MEM_rd_type = TYPE_WORD; mem_a = 32'h0000_5000 | ($urandom & 32'h0fff_fffc);
    MEM_rd_addr = mem_a;
    nmem = 0; done3 = 0;
    for (int k = 0; k < 8 && !done3; k++) begin
      #1;
      g = pick(1, 1, 0);
      chk("t3_if_rdy", IF_rd_rdy, (g == 1));
      chk("t3_mem_rdy", MEM_rd_rdy, (g == 2));
      nmem += int'(MEM_rd_rdy);
      model_grant(g, 1);
      step();
      if (g == 2) begin
        serve_read(1, TYPE_WORD, mem_a);
        mem_a = $urandom;
        MEM_rd_addr = mem_a;
      end else begin
        IF_rd_req = 0; MEM_rd_req = 0;
        serve_read(0, TYPE_WORD, 32'h1fc0_0100);
        done3 = 1;
      end
    end
    chk("t3_mem_grants", nmem, MAXR);
    chk("t3_run_cleared", dut.r_mem_run, 0);

    // 4: buffered line write blocks a same-line MEM read until bus_wr_done
    wd = {$urandom, $urandom, $urandom, $urandom};
    MEM_wr_req = 1; MEM_wr_type = TYPE_LINE; MEM_wr_addr = 32'h0000_2000;
    MEM_wr_wstrb = 4'hf; MEM_wr_data = wd;
    #1 chk("t4_wr_rdy", MEM_wr_rdy, 1'b1);
    step();
    MEM_wr_req = 0;
    #1;
    chk("t4_bus_wr_req", bus_wr_req, 1'b1);
    chk("t4_bus_wr_addr", bus_wr_addr, 32'h0000_2000);
    chk("t4_bus_wr_type", bus_wr_type, TYPE_LINE);
    chk("t4_bus_wr_data", bus_wr_data, wd);
    chk("t4_wr_full", MEM_wr_rdy, 1'b0);
    bus_wr_rdy = 1;
    step();
    bus_wr_rdy = 0;
    #1 chk("t4_wr_req_drop", bus_wr_req, 1'b0);
    MEM_rd_req = 1; MEM_rd_type = TYPE_WORD; MEM_rd_addr = 32'h0000_2008;
    IF_rd_req = 1; IF_rd_type = TYPE_WORD; IF_rd_addr = 32'h1fc0_0040;
    #1;
    chk("t4_mem_blocked", MEM_rd_rdy, 1'b0);
    chk("t4_if_granted", IF_rd_rdy, 1'b1);
    model_grant(1, 1);
    step();
    IF_rd_req = 0;
    serve_read(0, TYPE_WORD, 32'h1fc0_0040);
    #1 chk("t4_mem_still_blocked", MEM_rd_rdy, 1'b0);
    step();
    MEM_rd_addr = 32'h0000_2010;
    #1 chk("t4_other_line_ok", MEM_rd_rdy, 1'b1);
    model_grant(2, 0);
    step();
    MEM_rd_req = 0;
    serve_read(1, TYPE_WORD, 32'h0000_2010);
    MEM_rd_req = 1; MEM_rd_addr = 32'h0000_2008; bus_wr_done = 1;
    #1;
    chk("t4_blocked_done_cycle", MEM_rd_rdy, 1'b0);
    chk("t4_wr_rdy_on_done", MEM_wr_rdy, 1'b1);
    step();
    bus_wr_done = 0;
    #1 chk("t4_mem_rdy_after_done", MEM_rd_rdy, 1'b1);
    model_grant(2, 0);
    step();
    MEM_rd_req = 0;
    serve_read(1, TYPE_WORD, 32'h0000_2008);

    // 5: write response and new write in the same cycle
    MEM_wr_req = 1; MEM_wr_type = TYPE_WORD; MEM_wr_addr = 32'h0000_3000;
    MEM_wr_wstrb = 4'b0011; MEM_wr_data = {96'd0, $urandom};
    step();
    MEM_wr_req = 0;
    #1 chk("t5_first_wstrb", bus_wr_wstrb, 4'b0011);
    bus_wr_rdy = 1;
    step();
    bus_wr_rdy = 0;
    wd = {$urandom, $urandom, $urandom, $urandom};
    bus_wr_done = 1;
    MEM_wr_req = 1; MEM_wr_type = TYPE_LINE; MEM_wr_addr = 32'h0000_4000;
    MEM_wr_wstrb = 4'hf; MEM_wr_data = wd;
    #1;
    chk("t5_wr_rdy_same_cycle", MEM_wr_rdy, 1'b1);
    chk("t5_no_req_yet", bus_wr_req, 1'b0);
    step();
    bus_wr_done = 0; MEM_wr_req = 0;
    #1;
    chk("t5_new_req", bus_wr_req, 1'b1);
    chk("t5_new_addr", bus_wr_addr, 32'h0000_4000);
    chk("t5_new_data", bus_wr_data, wd);
    chk("t5_wb_valid", dut.u_wb.r_wb_valid, 1'b1);
    chk("t5_full", MEM_wr_rdy, 1'b0);
    bus_wr_rdy = 1;
    step();
    bus_wr_rdy = 0; bus_wr_done = 1;
    step();
    bus_wr_done = 0;
    #1 chk("t5_drained", MEM_wr_rdy, 1'b1);
    bus_wr_done = 1;
    step();
    bus_wr_done = 0;
    #1 chk("t5_stray_done", {MEM_wr_rdy, bus_wr_req}, 2'b10);

    // Randomised read traffic against the reference model
    if_p = 0; mem_p = 0;
    if_t = TYPE_WORD; mem_t = TYPE_WORD; if_a = 0; mem_a = 0;
    for (int it = 0; it < 30; it++) begin
      if (!if_p && $urandom_range(0, 1) == 1) begin
        if_p = 1; if_t = rtype(); if_a = $urandom;
      end
      if (!mem_p && $urandom_range(0, 2) != 0) begin
        mem_p = 1; mem_t = rtype(); mem_a = $urandom;
      end
      IF_rd_req = if_p; IF_rd_type = if_t; IF_rd_addr = if_a;
      MEM_rd_req = mem_p; MEM_rd_type = mem_t; MEM_rd_addr = mem_a;
      #1;
      g = pick(if_p, mem_p, 0);
      chk("rnd_if_rdy", IF_rd_rdy, (g == 1));
      chk("rnd_mem_rdy", MEM_rd_rdy, (g == 2));
      model_grant(g, if_p);
      step();
      chk("rnd_run", dut.r_mem_run, m_run);
      if (g == 1) begin
        if_p = 0; IF_rd_req = 0;
        serve_read(0, if_t, if_a);
      end else if (g == 2) begin
        mem_p = 0; MEM_rd_req = 0;
        serve_read(1, mem_t, mem_a);
      end
    end
    IF_rd_req = 0; MEM_rd_req = 0;
    step();

    // 6: reset in the middle of a response
    IF_rd_req = 1; IF_rd_type = TYPE_LINE; IF_rd_addr = 32'h1fc0_0000;
    #1 chk("t6_if_rdy", IF_rd_rdy, 1'b1);
    step();
    IF_rd_req = 0; bus_rd_rdy = 1;
    step();
    bus_rd_rdy = 0;
    bus_ret_valid = 1; bus_ret_data = $urandom;
    #1 chk("t6_beat1", IF_ret_valid, 1'b1);
    step();
    bus_ret_data = $urandom; resetn = 0;
    #1 chk("t6_all_zero", all_out, '0);
    step();
    resetn = 1; bus_ret_valid = 0; bus_ret_data = 0; m_run = 0;
    step();
    IF_rd_req = 1; IF_rd_type = TYPE_LINE; IF_rd_addr = 32'h1fc0_0000;
    #1 chk("t6_fresh_rdy", IF_rd_rdy, 1'b1);
    model_grant(1, 1);
    step();
    IF_rd_req = 0;
    serve_read(0, TYPE_LINE, 32'h1fc0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
